// File: rtl/counter_chk_pkg.sv
// Shared FSM state, mode encodings and Johnson code table for counter_checker.
// Johnson support in the design is enabled by COUNTER_CHECKER_JOHNSON_EN.
package counter_chk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StLocked
  } state_e;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_JOHN = 1'b1;

  // Legal 4-bit Johnson codes in sequence order; the array index is the decoded jidx.
  localparam logic [3:0] JOHN_CODES [8] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0111,
    4'b1111, 4'b1110, 4'b1100, 4'b1000
  };

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-value, legality flag and Johnson index for an observed counter value.
// Johnson mode and decode exist only when COUNTER_CHECKER_JOHNSON_EN is defined.
module counter_next_val
  import counter_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic [WIDTH-1:0] nxt,
  output logic             legal,
  output logic [2:0]       idx
);

  logic [WIDTH-1:0] bin_nxt;
  assign bin_nxt = q + WIDTH'(1);

`ifdef COUNTER_CHECKER_JOHNSON_EN
  logic [WIDTH-1:0] codes [2*WIDTH];
  logic             hit;
  logic [2:0]       hit_idx;

  for (genvar k = 0; k < 2 * WIDTH; k++) begin : g_code
    if (WIDTH == 4) begin : g_tab
      assign codes[k] = JOHN_CODES[k];
    end else begin : g_gen
      // Codes 0..WIDTH fill ones from the LSB; later codes drain them from the LSB.
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        assign codes[k][b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
      end
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < 2 * int'(WIDTH); k++) begin
      if (q == codes[k]) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  assign nxt   = (mode == MODE_JOHN) ? {q[WIDTH-2:0], ~q[WIDTH-1]} : bin_nxt;
  assign legal = (mode == MODE_BIN) || hit;
  assign idx   = hit_idx;
`else
  logic unused_mode;
  assign unused_mode = mode;

  assign nxt   = bin_nxt;
  assign legal = 1'b1;
  assign idx   = '0;
`endif

endmodule

// File: rtl/counter_checker.sv
// Tracks a binary or Johnson counter, locks after LOCK_CNT correct steps and counts errors.
// Johnson mode, illegal-code detection and jidx decode require COUNTER_CHECKER_JOHNSON_EN.
module counter_checker
  import counter_chk_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned LOCK_CNT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample,
  input  logic [WIDTH-1:0]     q,
  input  logic                 mode,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0]     exp_q,
  output logic [2:0]           jidx
);

  localparam logic [3:0] LockCnt = 4'(LOCK_CNT);

  state_e               state_q;
  logic   [3:0]         match_q;
  logic   [3:0]         match_inc;
  logic   [WIDTH-1:0]   nxt;
  logic                 legal;
  logic   [2:0]         idx;
  logic                 hit;
  logic                 is_john;
  logic                 mode_chg;
  logic [ERR_CNT_W-1:0] cnt_inc;

  counter_next_val #(
    .WIDTH(WIDTH)
  ) u_next (
    .q    (q),
    .mode (mode),
    .nxt  (nxt),
    .legal(legal),
    .idx  (idx)
  );

`ifdef COUNTER_CHECKER_JOHNSON_EN
  logic mode_q;
  assign is_john  = (mode == MODE_JOHN);
  assign mode_chg = (mode != mode_q) && (state_q != StIdle);
`else
  assign is_john  = 1'b0;
  assign mode_chg = 1'b0;
`endif

  assign hit       = (q == exp_q);
  assign match_inc = match_q + 4'd1;
  assign cnt_inc   = (err_cnt == '1) ? err_cnt : err_cnt + ERR_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      match_q <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      exp_q   <= '0;
      jidx    <= '0;
`ifdef COUNTER_CHECKER_JOHNSON_EN
      mode_q  <= MODE_BIN;
`endif
    end else begin
      err <= 1'b0;
`ifdef COUNTER_CHECKER_JOHNSON_EN
      mode_q <= mode;
`endif
      if (mode_chg) begin
        // Switching sequence type invalidates tracking; not an error.
        state_q <= StIdle;
        match_q <= '0;
        locked  <= 1'b0;
      end else if (sample) begin
        if (!legal) begin
          err     <= 1'b1;
          err_cnt <= cnt_inc;
          state_q <= StIdle;
          match_q <= '0;
          locked  <= 1'b0;
        end else begin
          exp_q <= nxt;
          if (is_john) begin
            jidx <= idx;
          end
          case (state_q)
            StIdle: begin
              match_q <= '0;
              state_q <= StAcquire;
            end
            StAcquire: begin
              if (hit) begin
                match_q <= match_inc;
                if (match_inc == LockCnt) begin
                  state_q <= StLocked;
                  locked  <= 1'b1;
                end
              end else begin
                match_q <= '0;
              end
            end
            StLocked: begin
              if (!hit) begin
                err     <= 1'b1;
                err_cnt <= cnt_inc;
                match_q <= '0;
                state_q <= StAcquire;
                locked  <= 1'b0;
              end
            end
            default: begin
              state_q <= StIdle;
              locked  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
